wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter driving the single write port (RegWrite, WriteReg, WriteData) of the MIPS register bank. It merges in-order pipeline writebacks with out-of-order results from the long-latency unit (multiply/divide, multi-cycle loads) through a small result FIFO. It also keeps a 32-entry pending-register scoreboard so decode can stall on operands whose long-latency result has not yet reached the bank.

## Interface
- LU_FIFO_DEPTH, 4: long-latency result FIFO depth; power of two, ≥2
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline writeback valid; no backpressure, always wins
- pipe_waddr  in  REG_ADDR_W  pipeline destination register
- pipe_wdata  in  DATA_32_W  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept; transfer when lu_valid && lu_ready
- lu_waddr  in  REG_ADDR_W  long-latency destination register
- lu_wdata  in  DATA_32_W  long-latency result
- issue_valid  in  1  long-latency op issued; mark issue_waddr pending
- issue_waddr  in  REG_ADDR_W  destination of issued op
- rd_addr1, rd_addr2  in  REG_ADDR_W  decode source registers
- rd_busy1, rd_busy2  out  1  combinational: scoreboard bit of rd_addrN
- RegWrite  out  1  registered bank write enable
- WriteReg  out  REG_ADDR_W  registered bank write address
- WriteData  out  DATA_32_W  registered bank write data

## Operation
- Output register loads every edge: pipe_we → pipeline entry (src=PIPE); else FIFO non-empty → pop head (src=LU); else RegWrite←0, WriteReg/WriteData hold.
- FIFO: push on lu_valid && lu_ready; pop only in cycles with pipe_we=0. No push→pop bypass; an entry pushed at edge t pops at edge t+1 at the earliest.
- lu_ready = !rst && (count < LU_FIFO_DEPTH), from registered count only; no dependence on the same-cycle pop. Full: lu_ready=0, producer holds.
- Count width $clog2(LU_FIFO_DEPTH)+1; read/write pointers wrap modulo depth.
- Scoreboard pend[31:0]: set pend[issue_waddr] on issue_valid; clear pend[WriteReg] on an edge where RegWrite=1 and src=LU (the edge the bank absorbs the write).
- Simultaneous set and clear of the same bit: set wins.
- Pipeline writes never touch the scoreboard. Decode guarantees no pipeline write to a pending register; the bench asserts this.
- Starvation: continuous pipe_we stalls the FIFO indefinitely. This is legal; decode stalls on rd_busy.

## Timing
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, lu_ready=0 while rst=1, count=0, pointers=0, pend=0, src=PIPE.
- Reset mid-operation flushes the FIFO and scoreboard in one cycle. In-flight long-latency results are discarded.
- Pipeline latency: pipe_we at cycle t → RegWrite=1 in cycle t+1.
- LU latency (empty FIFO, pipe idle): accepted at edge t → RegWrite=1 after edge t+1 → pend cleared and bank written at edge t+2.
- rd_busy reflects pend combinationally. An issue at edge t makes busy visible in cycle t+1.

## Configuration
- WB_ZERO_REG_DROP_EN defined: writes addressed to register 0 from either source are dropped. Pipeline entries are ignored. LU entries are still accepted and popped, but RegWrite stays 0. issue_valid to register 0 never sets pend[0], and rd_busy for address 0 is always 0.
- WB_ZERO_REG_DROP_EN undefined: register 0 is treated like any other register.

## Structure
- mips_pkg: reuse REG_ADDR_W and DATA_32_W. Add wb_entry_t struct {addr, data}, wb_src_t enum {WB_SRC_PIPE, WB_SRC_LU}, and WB_LU_FIFO_DEPTH_DEF=4.
- One sub-module, wb_fifo: synchronous FIFO of wb_entry_t with push/pop/full/empty/count. Arbitration and scoreboard live in wb_arbiter.

## Test plan
- Pipeline only: pipe_we=1, waddr=5, wdata=0xDEADBEEF at cycle 0 → cycle 1 RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; cycle 2 RegWrite=0.
- LU round trip: issue reg 9; lu 9/0x1234 accepted at edge 3 → rd_busy1 (rd_addr1=9)=1 until edge 5. RegWrite with 9/0x1234 in cycle 4–5, busy 0 from cycle 5.
- Contention: pipe_we every cycle for 6 cycles while 5 LU results arrive (depth 4) → lu_ready drops after the 4th accept. All pipe writes land in order, then the 4 FIFO entries, then the 5th, with no loss or reorder.
- Set/clear collision: issue_valid reg 7 on the same edge LU's reg 7 write is absorbed → pend[7] remains 1.
- Reset mid-burst: rst with FIFO holding 3 entries and pend=0x0000_0680 → next cycle count=0, pend=0, RegWrite=0, lu_ready=1 once rst falls.
- Zero register with WB_ZERO_REG_DROP_EN: pipe write to reg 0 → RegWrite stays 0. Issue reg 0 → rd_busy=0. Without the macro, RegWrite=1 with WriteReg=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths plus the writeback arbiter's entry/source types.
package mips_pkg;

   localparam int REG_ADDR_W           = 5;
   localparam int DATA_32_W            = 32;
   localparam int WB_LU_FIFO_DEPTH_DEF = 4;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_32_W-1:0]  data;
   } wb_entry_t;

   typedef enum logic {
      WB_SRC_PIPE = 1'b0,
      WB_SRC_LU   = 1'b1
   } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; head is read straight from storage so a
// pop can feed the output register in the same cycle.
module wb_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = WB_LU_FIFO_DEPTH_DEF,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  wb_entry_t     push_data,
   input  logic          pop,
   output wb_entry_t     head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   wb_entry_t         mem_reg [DEPTH];
   logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]     count_reg, count_next;
   logic              push_ok, pop_ok;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign head    = mem_reg[rd_ptr_reg];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop_ok)
         count_next = count_reg + CW'(1);
      else if (pop_ok && !push_ok)
         count_next = count_reg - CW'(1);
   end

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem_reg[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-bank writeback arbiter: pipeline writes win, long-latency results queue
// in a FIFO, and a pending scoreboard feeds decode stalls. Option: WB_ZERO_REG_DROP_EN.
module wb_arbiter
   import mips_pkg::*;
#(
   parameter int LU_FIFO_DEPTH = WB_LU_FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_we,
   input  logic [REG_ADDR_W-1:0] pipe_waddr,
   input  logic [DATA_32_W-1:0]  pipe_wdata,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [REG_ADDR_W-1:0] lu_waddr,
   input  logic [DATA_32_W-1:0]  lu_wdata,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_waddr,
   input  logic [REG_ADDR_W-1:0] rd_addr1,
   input  logic [REG_ADDR_W-1:0] rd_addr2,
   output logic                  rd_busy1,
   output logic                  rd_busy2,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] WriteReg,
   output logic [DATA_32_W-1:0]  WriteData
);

   localparam int NREGS = 2 ** REG_ADDR_W;
   localparam int CW    = $clog2(LU_FIFO_DEPTH) + 1;
`ifdef WB_ZERO_REG_DROP_EN
   localparam bit ZERO_DROP = 1'b1;
`else
   localparam bit ZERO_DROP = 1'b0;
`endif

   wb_entry_t             fifo_head;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [CW-1:0]         fifo_count;

   logic                  regwrite_reg, regwrite_next;
   logic [REG_ADDR_W-1:0] writereg_reg, writereg_next;
   logic [DATA_32_W-1:0]  writedata_reg, writedata_next;
   wb_src_t               src_reg, src_next;
   logic [NREGS-1:0]      pend_reg, set_vec, clr_vec;

   assign lu_ready  = !rst && (fifo_count < CW'(LU_FIFO_DEPTH));
   assign fifo_push = lu_valid && lu_ready && !fifo_full;

   wb_fifo #(.DEPTH(LU_FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ('{addr: lu_waddr, data: lu_wdata}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Dropped register-0 writes still consume their slot but leave the bank untouched.
   always_comb begin
      regwrite_next  = 1'b0;
      writereg_next  = writereg_reg;
      writedata_next = writedata_reg;
      src_next       = src_reg;
      fifo_pop       = 1'b0;
      if (pipe_we) begin
         if (!(ZERO_DROP && pipe_waddr == '0)) begin
            regwrite_next  = 1'b1;
            writereg_next  = pipe_waddr;
            writedata_next = pipe_wdata;
            src_next       = WB_SRC_PIPE;
         end
      end else if (!fifo_empty) begin
         fifo_pop = 1'b1;
         if (!(ZERO_DROP && fifo_head.addr == '0)) begin
            regwrite_next  = 1'b1;
            writereg_next  = fifo_head.addr;
            writedata_next = fifo_head.data;
            src_next       = WB_SRC_LU;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite_reg  <= 1'b0;
         writereg_reg  <= '0;
         writedata_reg <= '0;
         src_reg       <= WB_SRC_PIPE;
      end else begin
         regwrite_reg  <= regwrite_next;
         writereg_reg  <= writereg_next;
         writedata_reg <= writedata_next;
         src_reg       <= src_next;
      end
   end

   // A bit clears on the edge the bank absorbs the LU write; a same-edge issue re-sets it.
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_pend
         assign set_vec[gi] = !(ZERO_DROP && gi == 0) && issue_valid
                              && (issue_waddr == REG_ADDR_W'(gi));
         assign clr_vec[gi] = regwrite_reg && (src_reg == WB_SRC_LU)
                              && (writereg_reg == REG_ADDR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)
         pend_reg <= '0;
      else
         pend_reg <= (pend_reg & ~clr_vec) | set_vec;
   end

   assign rd_busy1  = pend_reg[rd_addr1];
   assign rd_busy2  = pend_reg[rd_addr2];
   assign RegWrite  = regwrite_reg;
   assign WriteReg  = writereg_reg;
   assign WriteData = writedata_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-level reference model predicts each
// cycle's bank write, lu_ready and busy flags; a monitor compares them.
module tb_wb_arbiter;
   import mips_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        issue_valid;
   logic [4:0]  issue_waddr;
   logic [4:0]  rd_addr1, rd_addr2;
   logic        rd_busy1, rd_busy2;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;

   always #5 clk = ~clk;

   wb_arbiter #(.LU_FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .pipe_we     (pipe_we),
      .pipe_waddr  (pipe_waddr),
      .pipe_wdata  (pipe_wdata),
      .lu_valid    (lu_valid),
      .lu_ready    (lu_ready),
      .lu_waddr    (lu_waddr),
      .lu_wdata    (lu_wdata),
      .issue_valid (issue_valid),
      .issue_waddr (issue_waddr),
      .rd_addr1    (rd_addr1),
      .rd_addr2    (rd_addr2),
      .rd_busy1    (rd_busy1),
      .rd_busy2    (rd_busy2),
      .RegWrite    (RegWrite),
      .WriteReg    (WriteReg),
      .WriteData   (WriteData)
   );

   typedef struct {
      bit          rw;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      bit          rdy;
      bit          busy1;
      bit          busy2;
   } exp_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   exp_t        exp_q[$];
   ent_t        mq[$];     // model of results queued for the bank
   ent_t        outq[$];   // producer: results waiting to be offered
   bit          pend_m[32];
   bit          m_rw, m_lu;
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   bit          lu_acc;
   int          checks = 0;
   int          failures = 0;

   function automatic bit dropped(logic [4:0] a);
`ifdef WB_ZERO_REG_DROP_EN
      return (a == 5'd0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Predict the state after the coming edge from the current inputs, then take the edge.
   task automatic cycle();
      exp_t e;
      ent_t h;
      lu_acc = 1'b0;
      if (rst) begin
         mq.delete();
         foreach (pend_m[i]) pend_m[i] = 1'b0;
         m_rw = 1'b0; m_lu = 1'b0; m_reg = '0; m_data = '0;
      end else begin
         assert (!(pipe_we && pend_m[pipe_waddr])) else $error("pipeline write to pending reg %0d", pipe_waddr);
         lu_acc = lu_valid && (mq.size() < DEPTH);
         if (m_rw && m_lu) pend_m[m_reg] = 1'b0;
         if (issue_valid && !dropped(issue_waddr)) pend_m[issue_waddr] = 1'b1;
         m_rw = 1'b0;
         if (pipe_we) begin
            if (!dropped(pipe_waddr)) begin
               m_rw = 1'b1; m_lu = 1'b0; m_reg = pipe_waddr; m_data = pipe_wdata;
            end
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (!dropped(h.addr)) begin
               m_rw = 1'b1; m_lu = 1'b1; m_reg = h.addr; m_data = h.data;
            end
         end
         if (lu_acc) mq.push_back('{lu_waddr, lu_wdata});
      end
      e.rw    = m_rw;
      e.wreg  = m_reg;
      e.wdata = m_data;
      e.rdy   = !rst && (mq.size() < DEPTH);
      e.busy1 = pend_m[rd_addr1];
      e.busy2 = pend_m[rd_addr2];
      exp_q.push_back(e);
      @(posedge clk);
      #2;
      if (lu_acc) begin
         void'(outq.pop_front());
         lu_valid = 1'b0;
      end
   endtask

   task automatic offer_lu();
      if (outq.size() > 0) begin
         lu_valid = 1'b1;
         lu_waddr = outq[0].addr;
         lu_wdata = outq[0].data;
      end else begin
         lu_valid = 1'b0;
      end
   endtask

   task automatic issue_cycle(logic [4:0] r);
      issue_valid = 1'b1;
      issue_waddr = r;
      cycle();
      issue_valid = 1'b0;
      outq.push_back('{r, $urandom});
   endtask

   // Monitor: one expected record per edge, compared 1 time unit after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("RegWrite", 32'(RegWrite), 32'(e.rw));
            chk("WriteReg", 32'(WriteReg), 32'(e.wreg));
            chk("WriteData", WriteData, e.wdata);
            chk("lu_ready", 32'(lu_ready), 32'(e.rdy));
            chk("rd_busy1", 32'(rd_busy1), 32'(e.busy1));
            chk("rd_busy2", 32'(rd_busy2), 32'(e.busy2));
            if (RegWrite)
               $display("WB t=%0t reg=%0d data=%h", $time, WriteReg, WriteData);
         end
      end
   end

   initial begin
      int tries;
      logic [4:0] r;
      rst = 1'b1; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
      lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
      issue_valid = 1'b0; issue_waddr = '0; rd_addr1 = '0; rd_addr2 = '0;
      cycle(); cycle();
      rst = 1'b0;

      // pipeline-only write
      pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
      cycle();
      pipe_we = 1'b0;
      cycle(); cycle();

      // LU round trip on reg 9
      rd_addr1 = 5'd9;
      issue_cycle(5'd9);
      repeat (5) begin offer_lu(); cycle(); end

      // contention: pipe every cycle while five LU results arrive
      for (int k = 10; k <= 14; k++) issue_cycle(5'(k));
      for (int k = 1; k <= 6; k++) begin
         pipe_we = 1'b1; pipe_waddr = 5'(k); pipe_wdata = $urandom;
         offer_lu(); cycle();
      end
      pipe_we = 1'b0;
      repeat (10) begin offer_lu(); cycle(); end

      // set/clear collision on reg 7
      rd_addr1 = 5'd7;
      issue_cycle(5'd7);
      offer_lu(); cycle();
      cycle();
      issue_valid = 1'b1; issue_waddr = 5'd7;
      cycle();
      issue_valid = 1'b0;
      cycle();
      outq.push_back('{5'd7, 32'h0000_7777});

      // reset with three FIFO entries and pend = 7,9,10
      rd_addr2 = 5'd10;
      issue_cycle(5'd9);
      issue_cycle(5'd10);
      for (int k = 1; k <= 3; k++) begin
         pipe_we = 1'b1; pipe_waddr = 5'(k); pipe_wdata = $urandom;
         offer_lu(); cycle();
      end
      pipe_we = 1'b0; lu_valid = 1'b0; rst = 1'b1;
      cycle();
      outq.delete();
      rst = 1'b0;
      cycle(); cycle();

      // register 0 via both sources
      rd_addr2 = 5'd0;
      pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h0BAD_F00D;
      cycle();
      pipe_we = 1'b0;
      issue_cycle(5'd0);
      repeat (4) begin offer_lu(); cycle(); end

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1; pipe_we = 1'b0; issue_valid = 1'b0; lu_valid = 1'b0;
            cycle();
            outq.delete();
            rst = 1'b0;
            continue;
         end
         issue_valid = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            for (tries = 0; tries < 8; tries++) begin
               r = 5'($urandom_range(0, 31));
               if (!pend_m[r]) begin
                  issue_valid = 1'b1; issue_waddr = r;
                  break;
               end
            end
         end
         pipe_we = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            for (tries = 0; tries < 8; tries++) begin
               r = 5'($urandom_range(0, 31));
               if (!pend_m[r] && !(issue_valid && r == issue_waddr)) begin
                  pipe_we = 1'b1; pipe_waddr = r; pipe_wdata = $urandom;
                  break;
               end
            end
         end
         if (!lu_valid && outq.size() > 0 && $urandom_range(0, 1) == 1) offer_lu();
         if ($urandom_range(0, 3) == 0) rd_addr1 = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) rd_addr2 = 5'($urandom_range(0, 31));
         r = issue_waddr;
         cycle();
         if (issue_valid) begin
            outq.push_back('{r, $urandom});
            issue_valid = 1'b0;
         end
      end

      pipe_we = 1'b0; issue_valid = 1'b0;
      repeat (40) begin offer_lu(); cycle(); end
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
